// File: rtl/mips32_dmem_arbiter.sv
// Two-port (CPU / host) arbiter in front of a single-ported data memory.
// Latency: grant is combinational. Writes commit at the grant edge. Read data arrives one cycle after the grant.
// Backpressure: a denied request must be held. A request dropped before its grant has no effect.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   cpu_req/we/addr/wdata -> cpu_gnt    CPU MEM-stage access, cpu_rvalid/cpu_rdata read return
//   host_req/we/addr/wdata -> host_gnt  host/loader access, host_rvalid/host_rdata read return
//   host_lock                           host asks to keep ownership after its grant
//   busy                                host owns memory in LOCKED state
//
// Optional feature: define DMEM_ARB_HOST_LOCK_EN to build the LOCKED state.
// When it is undefined, host_lock is ignored and busy is tied low.
module mips32_dmem_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 32,
  parameter int HOST_MAX_WAIT = 4   // legal 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy
);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [0:0]        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              lock_active;
  logic              host_boost;

  logic              acc_en;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  // LOCKED only holds while host_lock stays high. The cycle host_lock
  // drops is already arbitrated as ARB, so the CPU can win that cycle.
`ifdef DMEM_ARB_HOST_LOCK_EN
  assign lock_active = (state_q == ST_LOCKED) && host_lock;
`else
  logic unused_host_lock;
  logic unused_state_locked;
  assign lock_active         = 1'b0;
  assign unused_host_lock    = host_lock;
  assign unused_state_locked = (state_q == ST_LOCKED);
`endif

  assign host_boost = (starve_q == MAX_WAIT);
  assign busy       = lock_active;

  // Arbitration: LOCKED gives the host the memory. Otherwise the CPU has
  // fixed priority unless the host has starved for MAX_WAIT cycles.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (lock_active) begin
      host_gnt = host_req;
    end else if (host_req && (!cpu_req || host_boost)) begin
      host_gnt = 1'b1;
    end else begin
      cpu_gnt = cpu_req;
    end
  end

  always_comb begin
    state_d = ST_ARB;
`ifdef DMEM_ARB_HOST_LOCK_EN
    if (lock_active || (host_gnt && host_lock)) begin
      state_d = ST_LOCKED;
    end
`endif
  end

  // Starvation counter: counts denied host cycles, saturating at MAX_WAIT.
  always_comb begin
    starve_d = starve_q;
    if (!host_req || host_gnt) begin
      starve_d = 4'd0;
    end else if (!host_boost) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ARB;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Single memory access per cycle, steered by the winning port.
  assign acc_en    = cpu_gnt || host_gnt;
  assign acc_we    = host_gnt ? host_we    : cpu_we;
  assign acc_addr  = host_gnt ? host_addr  : cpu_addr;
  assign acc_wdata = host_gnt ? host_wdata : cpu_wdata;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (acc_en && acc_we) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  // Read return. rvalid is a one-cycle pulse. rdata holds until that
  // port's next read. Reset clears both, which also drops a read that was
  // granted while reset was asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      cpu_rdata   <= '0;
      host_rdata  <= '0;
    end else begin
      cpu_rvalid  <= cpu_gnt && !cpu_we;
      host_rvalid <= host_gnt && !host_we;
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata <= mem[acc_addr];
      end
      if (host_gnt && !host_we) begin
        host_rdata <= mem[acc_addr];
      end
    end
  end

endmodule

// File: tb/tb_mips32_dmem_arbiter.sv
// Self-checking bench for mips32_dmem_arbiter.
// A vector table drives grant checks, and a read-data scoreboard checks rvalid/rdata.
// Hand sequences cover locking, starvation with host_lock held, and reset.
module tb_mips32_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic        busy;

  always #5 clk = ~clk;

  mips32_dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .HOST_MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .busy(busy)
  );

  typedef struct {
    string       name;
    logic        creq, cwe;
    logic [7:0]  caddr;
    logic [31:0] cwd;
    logic        hreq, hwe;
    logic [7:0]  haddr;
    logic [31:0] hwd;
    logic        hlock;
    logic        ecg, ehg, ebusy;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model [256];
  logic [31:0] cq[$];
  logic [31:0] hq[$];
  logic [31:0] last_c = '0;
  logic [31:0] last_h = '0;
  vec_t        vt[$];

  function automatic vec_t mk(input string nm,
                              input logic creq, input logic cwe, input logic [7:0] caddr, input logic [31:0] cwd,
                              input logic hreq, input logic hwe, input logic [7:0] haddr, input logic [31:0] hwd,
                              input logic hlock, input logic ecg, input logic ehg, input logic ebusy);
    vec_t v;
    v.name = nm;   v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.hreq = hreq; v.hwe = hwe;   v.haddr = haddr; v.hwd = hwd; v.hlock = hlock;
    v.ecg = ecg;   v.ehg = ehg;   v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge: compares the read returns from the previous grant cycle.
  task automatic check_reads(input string nm);
    logic ec, eh;
    ec = (cq.size() > 0);
    eh = (hq.size() > 0);
    chk({nm, "/cpu_rvalid"}, 32'(cpu_rvalid), 32'(ec));
    if (ec) last_c = cq.pop_front();
    chk({nm, "/cpu_rdata"}, cpu_rdata, last_c);
    chk({nm, "/host_rvalid"}, 32'(host_rvalid), 32'(eh));
    if (eh) last_h = hq.pop_front();
    chk({nm, "/host_rdata"}, host_rdata, last_h);
  endtask

  task automatic drive(input vec_t v);
    cpu_req  = v.creq;  cpu_we  = v.cwe;  cpu_addr  = v.caddr; cpu_wdata  = v.cwd;
    host_req = v.hreq;  host_we = v.hwe;  host_addr = v.haddr; host_wdata = v.hwd;
    host_lock = v.hlock;
  endtask

  // Entered and left at a negedge.
  task automatic apply(input vec_t v);
    check_reads({"pre_", v.name});
    drive(v);
    #1;
    chk({v.name, "/cpu_gnt"},  32'(cpu_gnt),  32'(v.ecg));
    chk({v.name, "/host_gnt"}, 32'(host_gnt), 32'(v.ehg));
    chk({v.name, "/busy"},     32'(busy),     32'(v.ebusy));
    if (v.ecg) begin
      if (v.cwe) model[v.caddr] = v.cwd;
      else       cq.push_back(model[v.caddr]);
    end
    if (v.ehg) begin
      if (v.hwe) model[v.haddr] = v.hwd;
      else       hq.push_back(model[v.haddr]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state, inputs idle.
    @(negedge clk);
    chk("rst/cpu_rvalid",  32'(cpu_rvalid),  32'd0);
    chk("rst/host_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst/cpu_rdata",   cpu_rdata,  32'd0);
    chk("rst/host_rdata",  host_rdata, 32'd0);
    chk("rst/busy",        32'(busy),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // name, creq cwe caddr cwd, hreq hwe haddr hwd, hlock, exp cpu_gnt host_gnt busy
    vt.push_back(mk("idle",     0,0,8'h00,32'h0,  0,0,8'h00,32'h0,         0, 0,0,0));
    vt.push_back(mk("h_wr10",   0,0,8'h00,32'h0,  1,1,8'h10,32'hDEADBEEF,  0, 0,1,0));
    vt.push_back(mk("c_rd10",   1,0,8'h10,32'h0,  0,0,8'h00,32'h0,         0, 1,0,0));
    vt.push_back(mk("c_wr20",   1,1,8'h20,32'd5,  0,0,8'h00,32'h0,         0, 1,0,0));
    vt.push_back(mk("c_rd20",   1,0,8'h20,32'h0,  0,0,8'h00,32'h0,         0, 1,0,0));
    vt.push_back(mk("h_rd20",   0,0,8'h00,32'h0,  1,0,8'h20,32'h0,         0, 0,1,0));
    vt.push_back(mk("h_rd10",   0,0,8'h00,32'h0,  1,0,8'h10,32'h0,         0, 0,1,0));
    vt.push_back(mk("both_wr",  1,1,8'h30,32'h11, 1,1,8'h30,32'h22,        0, 1,0,0));
    vt.push_back(mk("h_drop",   1,0,8'h30,32'h0,  0,1,8'h30,32'h22,        0, 1,0,0));
    vt.push_back(mk("idle2",    0,0,8'h00,32'h0,  0,0,8'h00,32'h0,         0, 0,0,0));
    for (int k = 0; k < 10; k++)
      vt.push_back(mk("starve", 1,0,8'h20,32'h0, 1,0,8'h10,32'h0, 0, (k % 5) != 4, (k % 5) == 4, 0));

    for (int i = 0; i < vt.size(); i++) apply(vt[i]);

`ifdef DMEM_ARB_HOST_LOCK_EN
    // Enter LOCKED, hold 6 cycles with the CPU requesting, then release.
    apply(mk("lk_enter", 0,0,8'h00,32'h0, 1,1,8'h40,32'hA5A50000, 1, 0,1,0));
    for (int k = 0; k < 6; k++)
      apply(mk("lk_hold", 1,0,8'h40,32'h0, k != 2, 1,8'h40,32'hA5A50000 + 32'(k), 1, 0, k != 2, 1));
    apply(mk("lk_exit", 1,0,8'h40,32'h0, 1,0,8'h40,32'h0, 0, 1,0,0));
    apply(mk("lk_idle", 0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0, 0,0,0));

    // Reset while LOCKED returns to ARB with CPU priority.
    apply(mk("lk_enter2", 0,0,8'h00,32'h0, 1,1,8'h50,32'h77, 1, 0,1,0));
    check_reads("lk_rst_pre");
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h50;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h50; host_lock = 1'b1;
    #1;
    chk("lk_rst/busy_before",    32'(busy),    32'd1);
    chk("lk_rst/cpu_gnt_before", 32'(cpu_gnt), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("lk_rst/busy_in_rst",    32'(busy),     32'd0);
    chk("lk_rst/cpu_gnt_in_rst", 32'(cpu_gnt),  32'd1);
    chk("lk_rst/host_gnt_in_rst",32'(host_gnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_c = '0;
    last_h = '0;
    apply(mk("lk_post_rst", 1,0,8'h50,32'h0, 1,0,8'h50,32'h0, 1, 1,0,0));
    apply(mk("lk_post_idle", 0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0, 0,0,0));
`else
    // host_lock held high has no effect: same starvation pattern, never busy.
    for (int k = 0; k < 10; k++)
      apply(mk("nolock_starve", 1,0,8'h20,32'h0, 1,0,8'h10,32'h0, 1, (k % 5) != 4, (k % 5) == 4, 0));
    apply(mk("nolock_idle", 0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 1, 0,0,0));
`endif

    // Reset pulsed across a host read grant: no rvalid, memory intact.
    check_reads("rst_rd_pre");
    cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10; host_lock = 1'b0;
    #1;
    chk("rst_rd/host_gnt", 32'(host_gnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_rd/busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_rd/host_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_rd/host_rdata",  host_rdata,       32'd0);
    rst_n = 1'b1;
    host_req = 1'b0;
    last_c = '0;
    last_h = '0;
    apply(mk("post_rst_rd10", 1,0,8'h10,32'h0, 0,0,8'h00,32'h0, 0, 1,0,0));
    apply(mk("post_rst_rd30", 0,0,8'h00,32'h0, 1,0,8'h30,32'h0, 0, 0,1,0));
    apply(mk("drain", 0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0, 0,0,0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips32_dmem_arbiter.md
MIPS32_DMEM_ARBITER -- requirements
Module: mips32_dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, data memory word-address width; depth = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter HOST_MAX_WAIT, default 4, consecutive denied host-request cycles before host priority boost; legal range 1..15.
REQ-004 SHALL have ports:
 clk  in  1  single clock, all state updates on posedge.
 rst_n  in  1  asynchronous, active-low reset.
 cpu_req  in  1  CPU MEM-stage access request, held until cpu_gnt.
 cpu_we  in  1  1 = write (SW), 0 = read (LW).
 cpu_addr  in  ADDR_W  CPU word address.
 cpu_wdata  in  DATA_W  CPU write data.
 cpu_gnt  out  1  CPU access performed this cycle.
 cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse.
 cpu_rdata  out  DATA_W  CPU read data.
 host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host/loader port, same meaning as CPU.
 host_lock  in  1  host requests exclusive ownership after its grant.
 host_gnt, host_rvalid, host_rdata  out  1/1/DATA_W  host counterparts of CPU outputs.
 busy  out  1  high while host owns memory in LOCKED state.

Function
REQ-005 SHALL contain the DATA_W x 2**ADDR_W storage array; exactly one access (read or write) per cycle.
REQ-006 cpu_gnt/host_gnt SHALL be combinational from current requests and registered state; never both high.
REQ-007 Write SHALL commit at the posedge ending the grant cycle.
REQ-008 Read SHALL return data on the cycle after grant with the matching rvalid high for exactly one cycle; rdata holds value until next read of that port.
REQ-009 Read granted the cycle after a write to the same address SHALL return the new data.
REQ-010 FSM states: ARB, LOCKED.
REQ-011 In ARB, CPU SHALL have fixed priority over host unless starve counter == HOST_MAX_WAIT, then host wins.
REQ-012 Starve counter (4 bits) SHALL increment each cycle host_req is high and host_gnt low, saturate at HOST_MAX_WAIT, clear on host_gnt or host_req low.
REQ-013 ARB -> LOCKED on a host grant with host_lock high (when compiled in); LOCKED -> ARB on the first cycle host_lock is low.
REQ-014 In LOCKED, host SHALL be granted whenever host_req is high; cpu_gnt SHALL stay low; busy high.
REQ-015 A request deasserted before grant SHALL be dropped without any memory effect.

Reset
REQ-016 rst_n low SHALL asynchronously force: state ARB, starve counter 0, cpu_rvalid/host_rvalid 0, cpu_rdata/host_rdata 0, busy 0.
REQ-017 A read granted in the cycle reset asserts SHALL produce no rvalid; memory contents SHALL NOT be reset.
REQ-018 Reset asserted in LOCKED SHALL return to ARB with CPU priority on the first cycle after release.

Configuration
REQ-019 Macro DMEM_ARB_HOST_LOCK_EN defined: LOCKED state and REQ-013/014 implemented.
REQ-020 Macro undefined: host_lock port present but ignored, FSM never leaves ARB, busy tied 0.

Verification
REQ-021 Host write addr 0x10 = 0xDEADBEEF, then CPU read 0x10 -> cpu_rvalid next cycle, cpu_rdata = 0xDEADBEEF.
REQ-022 cpu_req and host_req high continuously, HOST_MAX_WAIT=4 -> 4 CPU grants, 5th cycle host_gnt, counter returns to 0.
REQ-023 CPU write 0x20 = 5 then CPU read 0x20 back-to-back -> cpu_rdata = 5 one cycle after the read grant.
REQ-024 With DMEM_ARB_HOST_LOCK_EN, host_lock high for 6 cycles with CPU requesting -> cpu_gnt 0, busy 1 all 6 cycles; CPU granted first cycle after host_lock drops.
REQ-025 rst_n pulsed low during a host read grant -> host_rvalid stays 0, state ARB, busy 0, memory data at that address unchanged.
REQ-026 Without DMEM_ARB_HOST_LOCK_EN, host_lock held high -> arbitration identical to REQ-022, busy never 1.
